// File: rtl/bp_sched_pkg.sv
// Shared types and defaults for the branch-predictor update scheduler.
// Carries the FSM state encoding, the buffered update record and a saturating add.
package bp_sched_pkg;

    localparam int BP_DEPTH = 4;
    localparam int BP_PC_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        STALL = 2'd2,
        FLUSH = 2'd3
    } state_t;

    typedef struct packed {
        logic [BP_PC_W-1:0] pc;
        logic               taken;
    } bp_upd_t;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/bp_update_scheduler_if.sv
// Bundle between branch resolution, the scheduler and the predictor write port.
// Optional statistics outputs exist only when BP_UPD_STATS_EN is defined.
interface bp_update_scheduler_if #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              upd_valid;
    logic              upd_ready;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic              hold;
    logic              flush;
    logic              bp_write_enabled;
    logic [PC_W-1:0]   bp_pc_bits_write;
    logic              bp_outcome;
    logic [CNT_W-1:0]  fifo_count;
    logic              busy;
`ifdef BP_UPD_STATS_EN
    logic [15:0]       stat_writes;
    logic [15:0]       stat_dropped;
`endif

    modport slave (
        input  upd_valid, upd_pc, upd_taken, hold, flush,
        output upd_ready, bp_write_enabled, bp_pc_bits_write, bp_outcome, fifo_count, busy
`ifdef BP_UPD_STATS_EN
        , output stat_writes, stat_dropped
`endif
    );

    modport master (
        output upd_valid, upd_pc, upd_taken, hold, flush,
        input  upd_ready, bp_write_enabled, bp_pc_bits_write, bp_outcome, fifo_count, busy
`ifdef BP_UPD_STATS_EN
        , input stat_writes, stat_dropped
`endif
    );

endinterface

// File: rtl/bp_update_fifo.sv
// Circular buffer of resolved-branch updates with occupancy count and synchronous clear.
// Head is read combinationally; clear overrides push/pop on the same edge.
module bp_update_fifo
    import bp_sched_pkg::*;
#(
    parameter  int DEPTH = BP_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_clear,
    input  bp_upd_t          i_dat,
    output bp_upd_t          o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    bp_upd_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage needs no reset: an empty buffer never exposes its contents.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (i_push && !i_pop)      r_count <= r_count + CNT_W'(1);
            else if (i_pop && !i_push) r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/bp_update_scheduler.sv
// Queues resolved-branch updates and drains one per cycle into the bimodal predictor write port.
// Optional BP_UPD_STATS_EN adds saturating write and flush-drop counters.
module bp_update_scheduler
    import bp_sched_pkg::*;
#(
    parameter int DEPTH = BP_DEPTH,
    parameter int PC_W  = BP_PC_W
) (
    input logic                   clk,
    input logic                   reset,
    bp_update_scheduler_if.slave  bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    state_t           r_state;
    bp_upd_t          w_in;
    bp_upd_t          w_head;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_full;
    logic             w_empty;
    logic             w_block;
    logic             w_ready;
    logic             w_push;
    logic             w_pop;

    // Flush blocks both sides in its own cycle and in the FLUSH cycle after it.
    assign w_block = bus.flush | (r_state == FLUSH);
    assign w_ready = reset & ~w_full & ~w_block;
    assign w_push  = bus.upd_valid & w_ready;
    assign w_pop   = ~w_empty & ~bus.hold & ~w_block;

    assign w_in.pc    = bus.upd_pc;
    assign w_in.taken = bus.upd_taken;

    bp_update_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (bus.flush),
        .i_dat   (w_in),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_cnt_nxt = w_count;
        if (w_push && !w_pop)      w_cnt_nxt = w_count + CNT_W'(1);
        else if (w_pop && !w_push) w_cnt_nxt = w_count - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else if (bus.flush) begin
            r_state <= FLUSH;
        end else if (r_state == FLUSH || w_cnt_nxt == '0) begin
            r_state <= IDLE;
        end else if (bus.hold) begin
            r_state <= STALL;
        end else begin
            r_state <= DRAIN;
        end
    end

    assign bus.upd_ready        = w_ready;
    assign bus.bp_write_enabled = w_pop;
    assign bus.bp_pc_bits_write = w_empty ? '0 : w_head.pc;
    assign bus.bp_outcome       = ~w_empty & w_head.taken;
    assign bus.fifo_count       = w_count;
    assign bus.busy             = ~w_empty | (r_state == FLUSH);

`ifdef BP_UPD_STATS_EN
    logic [15:0] r_stat_writes;
    logic [15:0] r_stat_dropped;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_writes  <= '0;
            r_stat_dropped <= '0;
        end else begin
            if (w_pop)     r_stat_writes  <= sat_add16(r_stat_writes, 16'd1);
            if (bus.flush) r_stat_dropped <= sat_add16(r_stat_dropped, 16'(w_count));
        end
    end

    assign bus.stat_writes  = r_stat_writes;
    assign bus.stat_dropped = r_stat_dropped;
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed self-checking bench for bp_update_scheduler (DEPTH=4, PC_W=16).
module tb_bp_update_scheduler;
    import bp_sched_pkg::*;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_fail;

    bp_update_scheduler_if #(.DEPTH(4), .PC_W(16)) u_if ();

    bp_update_scheduler #(.DEPTH(4), .PC_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        u_if.upd_valid = 1'b0; u_if.upd_pc = '0; u_if.upd_taken = 1'b0;
        u_if.hold = 1'b0; u_if.flush = 1'b0;
        #12;
        n_cmp++; if (u_if.bp_write_enabled !== 1'b0) begin n_fail++; $display("FAIL rst_we got=%0b exp=0", u_if.bp_write_enabled); end
        n_cmp++; if (u_if.bp_pc_bits_write !== 16'h0) begin n_fail++; $display("FAIL rst_pc got=%0h exp=0", u_if.bp_pc_bits_write); end
        n_cmp++; if (u_if.bp_outcome !== 1'b0) begin n_fail++; $display("FAIL rst_outcome got=%0b exp=0", u_if.bp_outcome); end
        n_cmp++; if (u_if.upd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%0b exp=0", u_if.upd_ready); end
        n_cmp++; if (u_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count got=%0d exp=0", u_if.fifo_count); end
        n_cmp++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0b exp=0", u_if.busy); end
`ifdef BP_UPD_STATS_EN
        n_cmp++; if (u_if.stat_writes !== 16'd0) begin n_fail++; $display("FAIL rst_stat_writes got=%0d exp=0", u_if.stat_writes); end
`endif
        tick();
        reset = 1'b1;
        tick();
        n_cmp++; if (u_if.upd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_rise got=%0b exp=1", u_if.upd_ready); end
        n_cmp++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL rst_state got=%0d exp=%0d", dut.r_state, IDLE); end
    endtask

    task automatic test_single();
        u_if.upd_valid = 1'b1; u_if.upd_pc = 16'h0104; u_if.upd_taken = 1'b1; u_if.hold = 1'b0;
        #1;
        n_cmp++; if (u_if.upd_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got=%0b exp=1", u_if.upd_ready); end
        n_cmp++; if (u_if.bp_write_enabled !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass got=%0b exp=0", u_if.bp_write_enabled); end
        tick();
        u_if.upd_valid = 1'b0;
        #1;
        n_cmp++; if (u_if.bp_write_enabled !== 1'b1) begin n_fail++; $display("FAIL single_we got=%0b exp=1", u_if.bp_write_enabled); end
        n_cmp++; if (u_if.bp_pc_bits_write !== 16'h0104) begin n_fail++; $display("FAIL single_pc got=%0h exp=0104", u_if.bp_pc_bits_write); end
        n_cmp++; if (u_if.bp_outcome !== 1'b1) begin n_fail++; $display("FAIL single_outcome got=%0b exp=1", u_if.bp_outcome); end
        n_cmp++; if (u_if.fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count1 got=%0d exp=1", u_if.fifo_count); end
        tick();
        n_cmp++; if (u_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_count0 got=%0d exp=0", u_if.fifo_count); end
        n_cmp++; if (u_if.bp_write_enabled !== 1'b0) begin n_fail++; $display("FAIL single_we_off got=%0b exp=0", u_if.bp_write_enabled); end
        n_cmp++; if (u_if.bp_pc_bits_write !== 16'h0) begin n_fail++; $display("FAIL single_pc_empty got=%0h exp=0", u_if.bp_pc_bits_write); end
    endtask

    task automatic test_hold_fill();
        u_if.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            u_if.upd_valid = 1'b1; u_if.upd_pc = 16'h0200 + 16'(i); u_if.upd_taken = ((i % 2) == 1);
            #1;
            n_cmp++; if (u_if.upd_ready !== (i < 4)) begin n_fail++; $display("FAIL fill_ready[%0d] got=%0b exp=%0b", i, u_if.upd_ready, (i < 4)); end
            n_cmp++; if (u_if.bp_write_enabled !== 1'b0) begin n_fail++; $display("FAIL fill_we[%0d] got=%0b exp=0", i, u_if.bp_write_enabled); end
            tick();
        end
        n_cmp++; if (u_if.fifo_count !== 3'd4) begin n_fail++; $display("FAIL fill_count got=%0d exp=4", u_if.fifo_count); end
        n_cmp++; if (dut.r_state !== STALL) begin n_fail++; $display("FAIL fill_state got=%0d exp=%0d", dut.r_state, STALL); end
        // Full with a pop in the same cycle still refuses the offer.
        u_if.hold = 1'b0; u_if.upd_pc = 16'h02FF;
        #1;
        n_cmp++; if (u_if.upd_ready !== 1'b0) begin n_fail++; $display("FAIL full_pop_ready got=%0b exp=0", u_if.upd_ready); end
        n_cmp++; if (u_if.bp_write_enabled !== 1'b1) begin n_fail++; $display("FAIL drain_we[0] got=%0b exp=1", u_if.bp_write_enabled); end
        n_cmp++; if (u_if.bp_pc_bits_write !== 16'h0200) begin n_fail++; $display("FAIL drain_pc[0] got=%0h exp=0200", u_if.bp_pc_bits_write); end
        tick();
        u_if.upd_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1;
            n_cmp++; if (u_if.bp_write_enabled !== 1'b1) begin n_fail++; $display("FAIL drain_we[%0d] got=%0b exp=1", i, u_if.bp_write_enabled); end
            n_cmp++; if (u_if.bp_pc_bits_write !== 16'h0200 + 16'(i)) begin n_fail++; $display("FAIL drain_pc[%0d] got=%0h exp=%0h", i, u_if.bp_pc_bits_write, 16'h0200 + 16'(i)); end
            n_cmp++; if (u_if.bp_outcome !== ((i % 2) == 1)) begin n_fail++; $display("FAIL drain_outcome[%0d] got=%0b exp=%0b", i, u_if.bp_outcome, ((i % 2) == 1)); end
            tick();
        end
        n_cmp++; if (u_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL drain_count got=%0d exp=0", u_if.fifo_count); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 12; k++) begin
            u_if.upd_valid = 1'b1; u_if.upd_pc = 16'h0300 + 16'(k); u_if.upd_taken = ((k % 2) == 1);
            #1;
            n_cmp++; if (u_if.upd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", k, u_if.upd_ready); end
            if (k > 0) begin
                n_cmp++; if (u_if.bp_write_enabled !== 1'b1) begin n_fail++; $display("FAIL b2b_we[%0d] got=%0b exp=1", k, u_if.bp_write_enabled); end
                n_cmp++; if (u_if.bp_pc_bits_write !== 16'h0300 + 16'(k - 1)) begin n_fail++; $display("FAIL b2b_pc[%0d] got=%0h exp=%0h", k, u_if.bp_pc_bits_write, 16'h0300 + 16'(k - 1)); end
                n_cmp++; if (u_if.bp_outcome !== (((k - 1) % 2) == 1)) begin n_fail++; $display("FAIL b2b_outcome[%0d] got=%0b exp=%0b", k, u_if.bp_outcome, (((k - 1) % 2) == 1)); end
                n_cmp++; if (u_if.fifo_count !== 3'd1) begin n_fail++; $display("FAIL b2b_count[%0d] got=%0d exp=1", k, u_if.fifo_count); end
            end
            tick();
        end
        u_if.upd_valid = 1'b0;
        #1;
        n_cmp++; if (u_if.bp_pc_bits_write !== 16'h030B) begin n_fail++; $display("FAIL b2b_last_pc got=%0h exp=030b", u_if.bp_pc_bits_write); end
        n_cmp++; if (u_if.bp_write_enabled !== 1'b1) begin n_fail++; $display("FAIL b2b_last_we got=%0b exp=1", u_if.bp_write_enabled); end
        tick();
        n_cmp++; if (u_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL b2b_count_end got=%0d exp=0", u_if.fifo_count); end
`ifdef BP_UPD_STATS_EN
        n_cmp++; if (u_if.stat_writes !== 16'd17) begin n_fail++; $display("FAIL stat_writes got=%0d exp=17", u_if.stat_writes); end
`endif
    endtask

    task automatic test_flush();
        u_if.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            u_if.upd_valid = 1'b1; u_if.upd_pc = 16'h0400 + 16'(i); u_if.upd_taken = 1'b1;
            tick();
        end
        u_if.upd_pc = 16'h04FF; u_if.hold = 1'b0; u_if.flush = 1'b1;
        #1;
        n_cmp++; if (u_if.fifo_count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count got=%0d exp=3", u_if.fifo_count); end
        n_cmp++; if (u_if.upd_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%0b exp=0", u_if.upd_ready); end
        n_cmp++; if (u_if.bp_write_enabled !== 1'b0) begin n_fail++; $display("FAIL flush_we got=%0b exp=0", u_if.bp_write_enabled); end
        tick();
        u_if.flush = 1'b0;
        #1;
        n_cmp++; if (u_if.upd_ready !== 1'b0) begin n_fail++; $display("FAIL flushst_ready got=%0b exp=0", u_if.upd_ready); end
        n_cmp++; if (u_if.bp_write_enabled !== 1'b0) begin n_fail++; $display("FAIL flushst_we got=%0b exp=0", u_if.bp_write_enabled); end
        n_cmp++; if (u_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL flushst_count got=%0d exp=0", u_if.fifo_count); end
        n_cmp++; if (u_if.busy !== 1'b1) begin n_fail++; $display("FAIL flushst_busy got=%0b exp=1", u_if.busy); end
`ifdef BP_UPD_STATS_EN
        n_cmp++; if (u_if.stat_dropped !== 16'd3) begin n_fail++; $display("FAIL stat_dropped got=%0d exp=3", u_if.stat_dropped); end
`endif
        tick();
        u_if.upd_valid = 1'b0;
        #1;
        n_cmp++; if (u_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL postflush_count got=%0d exp=0", u_if.fifo_count); end
        n_cmp++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL postflush_busy got=%0b exp=0", u_if.busy); end
        n_cmp++; if (u_if.upd_ready !== 1'b1) begin n_fail++; $display("FAIL postflush_ready got=%0b exp=1", u_if.upd_ready); end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        u_if.hold = 1'b1;
        for (int i = 0; i < 2; i++) begin
            u_if.upd_valid = 1'b1; u_if.upd_pc = 16'h0500 + 16'(i); u_if.upd_taken = 1'b0;
            tick();
        end
        u_if.upd_valid = 1'b0; u_if.hold = 1'b0;
        #1;
        n_cmp++; if (u_if.bp_write_enabled !== 1'b1) begin n_fail++; $display("FAIL middrain_we got=%0b exp=1", u_if.bp_write_enabled); end
        n_cmp++; if (u_if.fifo_count !== 3'd2) begin n_fail++; $display("FAIL middrain_count got=%0d exp=2", u_if.fifo_count); end
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (u_if.bp_write_enabled !== 1'b0) begin n_fail++; $display("FAIL async_we got=%0b exp=0", u_if.bp_write_enabled); end
        n_cmp++; if (u_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL async_count got=%0d exp=0", u_if.fifo_count); end
        n_cmp++; if (u_if.upd_ready !== 1'b0) begin n_fail++; $display("FAIL async_ready got=%0b exp=0", u_if.upd_ready); end
        tick();
        reset = 1'b1;
        tick();
        n_cmp++; if (u_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL rel_count got=%0d exp=0", u_if.fifo_count); end
        n_cmp++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL rel_busy got=%0b exp=0", u_if.busy); end
        n_cmp++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL rel_state got=%0d exp=%0d", dut.r_state, IDLE); end
`ifdef BP_UPD_STATS_EN
        n_cmp++; if (u_if.stat_writes !== 16'd0) begin n_fail++; $display("FAIL rel_stat_writes got=%0d exp=0", u_if.stat_writes); end
`endif
    endtask

    task automatic test_same_pc();
        u_if.hold = 1'b1;
        tick();
        n_cmp++; if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL hold_empty_state got=%0d exp=%0d", dut.r_state, IDLE); end
        n_cmp++; if (u_if.busy !== 1'b0) begin n_fail++; $display("FAIL hold_empty_busy got=%0b exp=0", u_if.busy); end
        u_if.hold = 1'b0;
        u_if.upd_valid = 1'b1; u_if.upd_pc = 16'h0600; u_if.upd_taken = 1'b0;
        tick();
        u_if.upd_taken = 1'b1;
        #1;
        n_cmp++; if (u_if.bp_write_enabled !== 1'b1) begin n_fail++; $display("FAIL same_we0 got=%0b exp=1", u_if.bp_write_enabled); end
        n_cmp++; if (u_if.bp_pc_bits_write !== 16'h0600) begin n_fail++; $display("FAIL same_pc0 got=%0h exp=0600", u_if.bp_pc_bits_write); end
        n_cmp++; if (u_if.bp_outcome !== 1'b0) begin n_fail++; $display("FAIL same_outcome0 got=%0b exp=0", u_if.bp_outcome); end
        tick();
        u_if.upd_valid = 1'b0;
        #1;
        n_cmp++; if (u_if.bp_write_enabled !== 1'b1) begin n_fail++; $display("FAIL same_we1 got=%0b exp=1", u_if.bp_write_enabled); end
        n_cmp++; if (u_if.bp_pc_bits_write !== 16'h0600) begin n_fail++; $display("FAIL same_pc1 got=%0h exp=0600", u_if.bp_pc_bits_write); end
        n_cmp++; if (u_if.bp_outcome !== 1'b1) begin n_fail++; $display("FAIL same_outcome1 got=%0b exp=1", u_if.bp_outcome); end
        tick();
        n_cmp++; if (u_if.bp_write_enabled !== 1'b0) begin n_fail++; $display("FAIL same_we_end got=%0b exp=0", u_if.bp_write_enabled); end
        n_cmp++; if (u_if.fifo_count !== 3'd0) begin n_fail++; $display("FAIL same_count_end got=%0d exp=0", u_if.fifo_count); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_single();
        test_hold_fill();
        test_back_to_back();
        test_flush();
        test_reset_mid_drain();
        test_same_pc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
- Sits between the execute-stage branch resolution logic and the single write port of the bimodal predictor.
- Buffers resolved-branch updates (PC, taken) in a small FIFO and drains at most one per cycle into the predictor's write_enabled/pc_bits_write/outcome inputs.
- Supports a pipeline hold (pause draining) and a flush that discards all pending updates on pipeline redirect.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- PC_W, 16, PC width; matches the predictor pc_bits width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- upd_valid  in  1  resolved-branch update offered.
- upd_ready  out  1  scheduler accepts the update this cycle.
- upd_pc  in  PC_W  PC of the resolved branch.
- upd_taken  in  1  resolved outcome (1 = taken).
- hold  in  1  suppress predictor writes this cycle.
- flush  in  1  discard all buffered updates.
- bp_write_enabled  out  1  to predictor write_enabled.
- bp_pc_bits_write  out  PC_W  to predictor pc_bits_write.
- bp_outcome  out  1  to predictor outcome.
- fifo_count  out  CNT_W  number of buffered entries.
- busy  out  1  high when the FIFO is non-empty or state is FLUSH.

Behaviour:
- Reset (reset low, async):
  - Pointers and count go to 0; state goes to IDLE.
  - bp_write_enabled=0, bp_pc_bits_write=0, bp_outcome=0, upd_ready=0, fifo_count=0, busy=0.
  - upd_ready rises in the first cycle after reset deasserts.
- FSM states: IDLE, DRAIN, STALL, FLUSH.
  - IDLE: FIFO empty. A push moves to DRAIN; hold during a push moves to STALL.
  - DRAIN: FIFO non-empty, hold=0. Pops one entry per cycle. Returns to IDLE when the last entry pops with no concurrent push.
  - STALL: FIFO non-empty, hold=1. Returns to DRAIN when hold=0.
  - FLUSH: entered on any cycle with flush=1, from any state. Lasts exactly one cycle, then IDLE.
- Priority: flush > hold > drain/push.
- Push:
  - Occurs when upd_valid & upd_ready.
  - upd_ready = !full & state!=FLUSH & !flush (combinational).
  - When full, upd_ready=0 even if a pop happens the same cycle. There is no pass-through.
- Pop / write:
  - bp_write_enabled = !empty & !hold & !flush & state!=FLUSH (combinational).
  - bp_pc_bits_write and bp_outcome are driven from the head entry.
  - When bp_write_enabled=0 they still show the head entry, or 0 when empty.
  - The head pops on the same edge on which the predictor samples.
- Latency: an update accepted at edge N appears on bp_write_enabled in cycle N+1 at the earliest. There is no bypass.
- Ordering: strict FIFO. Two updates to the same PC are both applied, in order, with no coalescing.
- Simultaneous push and pop (not full): count unchanged, both pointers advance.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. full = (count==DEPTH), empty = (count==0).
- Flush:
  - At the edge where flush=1, pointers and count are zeroed.
  - No write occurs in the flush cycle. A push offered in that cycle is not accepted.
  - The FLUSH state blocks writes and pushes for one further cycle.
- Hold with an empty FIFO has no effect beyond keeping state IDLE.
- Reset mid-drain: all buffered entries are lost and the write is aborted asynchronously.

Optional Feature:
- Macro: BP_UPD_STATS_EN.
- Defined: adds two outputs.
  - stat_writes (16 bit): counts cycles with bp_write_enabled=1.
  - stat_dropped (16 bit): adds fifo_count on each flush.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Package bp_sched_pkg:
  - state enum (IDLE, DRAIN, STALL, FLUSH).
  - bp_upd_t struct {pc[PC_W-1:0], taken}.
  - Localparam defaults for DEPTH and PC_W.
- Sub-module bp_update_fifo: storage, pointers, count and full/empty, with push, pop and clear inputs.
- The FSM, handshake and stats logic stay in the top.

Test Plan:
- Reset then push PC 16'h0104 taken, hold=0 -> next cycle bp_write_enabled=1, bp_pc_bits_write=16'h0104, bp_outcome=1; fifo_count returns to 0 after that edge.
- Push 5 updates back-to-back with hold=1 and DEPTH=4 -> 4 accepted; upd_ready=0 on the 5th offer; fifo_count=4; no writes occur. Release hold -> 4 writes in order on 4 consecutive cycles.
- Continuous push and pop for 12 cycles -> pointers wrap 3 times; output order matches input; fifo_count stays at 1.
- With 3 entries buffered, pulse flush while upd_valid=1 -> no write in the flush cycle or the FLUSH cycle; push not accepted; fifo_count=0. With BP_UPD_STATS_EN, stat_dropped=3.
- Assert reset mid-drain with 2 entries buffered -> bp_write_enabled drops immediately (async); after release, fifo_count=0 and state is IDLE.
- Two pushes of the same PC, one not-taken and then one taken -> two separate writes in order (outcome 0 then 1).
